ecc_secded_pipe: RTL and testbench

- Parametrised, pipelined SECDED check-and-correct unit for cache read data. Generalises the fixed 32-bit syndrome generator to any data width.
- Computes the extended-Hamming syndrome, corrects single-bit errors and flags double-bit errors.
- Sits between the cache data array read port and the load-return path. Uses a valid/ready handshake and keeps saturating error-event counters for scrub and diagnostic software.

---
 rtl/ecc_secded_pipe.sv | 148 ++++++++++++++
 tb/tb_ecc_secded_pipe.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_secded_pipe.sv
// ecc_secded_pipe: two-stage SECDED check/correct unit for cache read data,
// with valid/ready flow control and saturating CE/UE event counters.
module ecc_secded_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16,
    // Smallest p with 2^p >= DATA_W+p+1, valid for DATA_W in 4..128
    localparam int unsigned P = (DATA_W <= 4)   ? 3 :
                                (DATA_W <= 11)  ? 4 :
                                (DATA_W <= 26)  ? 5 :
                                (DATA_W <= 57)  ? 6 :
                                (DATA_W <= 120) ? 7 : 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [P:0]        in_chk,
    input  logic              correct_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [P-1:0]      out_synd,
    output logic              out_ce,
    output logic              out_ue,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  ce_count,
    output logic [CNT_W-1:0]  ue_count
);

    localparam int unsigned N = DATA_W + P;

    // Codeword position of data bit j: j-th non-power-of-two position from 1
    function automatic int unsigned data_pos(input int unsigned j);
        int unsigned pos;
        int unsigned cnt;
        pos = 0;
        cnt = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            if ((k & (k - 1)) != 0) begin
                if (cnt == j) pos = k;
                cnt++;
            end
        end
        return pos;
    endfunction

    logic [7:0]        pos_tab [DATA_W];
    logic [P-1:0]      chk_calc;
    logic              e_in;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [P-1:0]      s1_synd;
    logic              s1_e;
    logic              s1_cen;

    logic [DATA_W-1:0] fix_data;
    logic              ce_nxt;
    logic              ue_nxt;

    logic              s1_adv;
    logic              s2_adv;

    for (genvar j = 0; j < int'(DATA_W); j++) begin : g_pos
        assign pos_tab[j] = 8'(data_pos(j));
    end

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;

    // Recompute Hamming check bits and the overall parity of the received word
    always_comb begin
        chk_calc = '0;
        for (int j = 0; j < int'(DATA_W); j++) begin
            for (int i = 0; i < int'(P); i++) begin
                if (pos_tab[j][i]) chk_calc[i] = chk_calc[i] ^ in_data[j];
            end
        end
        e_in = (^in_data) ^ (^in_chk);
    end

    // Classify the error and flip the addressed data bit when correction is enabled
    always_comb begin
        fix_data = s1_data;
        ce_nxt   = 1'b0;
        ue_nxt   = 1'b0;
        if (s1_e) begin
            if (32'(s1_synd) > N) ue_nxt = 1'b1;
            else                  ce_nxt = 1'b1;
        end else if (s1_synd != '0) begin
            ue_nxt = 1'b1;
        end
        // Syndromes of zero, check positions or out-of-range match no data bit
        if (s1_e && s1_cen) begin
            for (int j = 0; j < int'(DATA_W); j++) begin
                if (pos_tab[j] == 8'(s1_synd)) fix_data[j] = ~s1_data[j];
            end
        end
    end

    // Pipeline registers; each stage holds its contents while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_synd   <= '0;
            s1_e      <= 1'b0;
            s1_cen    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_synd  <= '0;
            out_ce    <= 1'b0;
            out_ue    <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_valid && in_ready) begin
                s1_data <= in_data;
                s1_synd <= chk_calc ^ in_chk[P-1:0];
                s1_e    <= e_in;
                s1_cen  <= correct_en;
            end
            if (s2_adv) out_valid <= s1_valid;
            if (s1_adv) begin
                out_data <= s1_cen ? fix_data : s1_data;
                out_synd <= s1_synd;
                out_ce   <= ce_nxt;
                out_ue   <= ue_nxt;
            end
        end
    end

    // Saturating error-event counters, advanced on output handshake; clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_count <= '0;
            ue_count <= '0;
        end else if (cnt_clr) begin
            ce_count <= '0;
            ue_count <= '0;
        end else if (out_valid && out_ready) begin
            if (out_ce && (ce_count != '1)) ce_count <= ce_count + CNT_W'(1);
            if (out_ue && (ue_count != '1)) ue_count <= ue_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// tb_ecc_secded_pipe: randomized and directed check of ecc_secded_pipe
// against a codeword-level SECDED reference model and an in-order scoreboard.
module tb_ecc_secded_pipe;

    localparam int unsigned DW   = 32;
    localparam int unsigned PW   = 6;
    localparam int unsigned CW   = 4;
    localparam int unsigned NPOS = DW + PW;
    localparam int          CMAX = (1 << CW) - 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [PW-1:0] synd;
        logic          ce;
        logic          ue;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [PW:0]   in_chk;
    logic          correct_en;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [PW-1:0] out_synd;
    logic          out_ce;
    logic          out_ue;
    logic          cnt_clr;
    logic [CW-1:0] ce_count;
    logic [CW-1:0] ue_count;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            n_out = 0;
    int            dpos[DW];
    int            model_ce = 0;
    int            model_ue = 0;
    logic          lat_chk = 1'b0;
    logic          clr_on_out = 1'b0;
    logic          stall_prev = 1'b0;
    logic [DW+PW+2:0] prev_out = '0;
    logic [DW-1:0] last_data;
    logic [PW-1:0] last_synd;
    logic          last_ce;
    logic          last_ue;

    ecc_secded_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chk(in_chk),
        .correct_en(correct_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_synd(out_synd), .out_ce(out_ce), .out_ue(out_ue),
        .cnt_clr(cnt_clr), .ce_count(ce_count), .ue_count(ue_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check bits for a clean word: Hamming bits are the XOR of set data positions
    function automatic logic [PW:0] encode(input logic [DW-1:0] d);
        int s;
        logic [PW:0] c;
        s = 0;
        for (int j = 0; j < int'(DW); j++) if (d[j]) s = s ^ dpos[j];
        c[PW-1:0] = PW'(s);
        c[PW] = (^d) ^ (^c[PW-1:0]);
        return c;
    endfunction

    // Reference decode: assemble the full codeword and XOR positions of its ones
    function automatic exp_t model(input logic [DW-1:0] d, input logic [PW:0] c, input logic cen);
        logic [NPOS:0] cw;
        int s;
        logic e;
        exp_t r;
        cw = '0;
        for (int j = 0; j < int'(DW); j++) cw[dpos[j]] = d[j];
        for (int i = 0; i < int'(PW); i++) cw[1 << i] = c[i];
        s = 0;
        for (int p = 1; p <= int'(NPOS); p++) if (cw[p]) s = s ^ p;
        e = (^cw) ^ c[PW];
        r.data = d;
        r.synd = PW'(s);
        r.ce = 1'b0;
        r.ue = 1'b0;
        r.cyc = 0;
        if (e) begin
            if (s > int'(NPOS)) r.ue = 1'b1;
            else begin
                r.ce = 1'b1;
                if (cen) for (int j = 0; j < int'(DW); j++) if (dpos[j] == s) r.data[j] = ~d[j];
            end
        end else if (s != 0) begin
            r.ue = 1'b1;
        end
        return r;
    endfunction

    // One clock cycle: drive inputs at negedge, then account both handshakes
    task automatic tick(input logic v, input logic [DW-1:0] d, input logic [PW:0] c,
                        input logic cen, input logic ordy, input logic clr, output logic acc);
        exp_t e;
        @(negedge clk);
        cyc++;
        check("ce_count", 64'(ce_count), 64'(model_ce));
        check("ue_count", 64'(ue_count), 64'(model_ue));
        in_valid   = v;
        in_data    = d;
        in_chk     = c;
        correct_en = cen;
        out_ready  = ordy;
        cnt_clr    = clr | (clr_on_out & out_valid);
        #1;
        if (stall_prev) check("hold_stable", 64'({out_valid, out_data, out_synd, out_ce, out_ue}), 64'(prev_out));
        check("in_ready", 64'(in_ready), 64'(!(sb.size() == 2 && !out_ready)));
        acc = in_valid & in_ready;
        if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                check("spurious_out", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_synd", 64'(out_synd), 64'(e.synd));
                check("out_flags", 64'({out_ce, out_ue}), 64'({e.ce, e.ue}));
                if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'(2));
            end
            last_data = out_data;
            last_synd = out_synd;
            last_ce   = out_ce;
            last_ue   = out_ue;
            if (!cnt_clr) begin
                if (out_ce && model_ce < CMAX) model_ce++;
                if (out_ue && model_ue < CMAX) model_ue++;
            end
        end
        if (cnt_clr) begin
            model_ce = 0;
            model_ue = 0;
        end
        if (acc) begin
            e = model(d, c, cen);
            e.cyc = cyc;
            sb.push_back(e);
        end
        stall_prev = out_valid & !out_ready;
        prev_out = {out_valid, out_data, out_synd, out_ce, out_ue};
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [PW:0] c, input logic cen);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            tick(1'b1, d, c, cen, 1'b1, 1'b0, acc);
            n++;
        end
        if (!acc) check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        logic acc;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'(0));
        tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
        tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    endtask

    // Corrupt a clean word: 0 none, 1 data bit, 2 check bit, 3 double data, 4 data+check
    task automatic corrupt(input int kind, inout logic [DW-1:0] d, inout logic [PW:0] c);
        int a, b;
        a = int'($urandom_range(DW - 1));
        b = (a + 1 + int'($urandom_range(DW - 2))) % int'(DW);
        case (kind)
            1: d[a] = ~d[a];
            2: c[a % (PW + 1)] = ~c[a % (PW + 1)];
            3: begin d[a] = ~d[a]; d[b] = ~d[b]; end
            4: begin d[a] = ~d[a]; c[b % (PW + 1)] = ~c[b % (PW + 1)]; end
            default: ;
        endcase
    endtask

    initial begin : main
        logic [DW-1:0] w;
        logic [DW-1:0] d;
        logic [PW:0]   good;
        logic [PW:0]   c;
        logic [DW-1:0] words[8];
        logic acc;
        int idx;
        int base;

        begin
            int cnt;
            cnt = 0;
            for (int p = 1; p <= int'(NPOS); p++) begin
                if ((p & (p - 1)) != 0) begin
                    dpos[cnt] = p;
                    cnt++;
                end
            end
        end

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_chk = '0;
        correct_en = 1'b0;
        out_ready = 1'b0;
        cnt_clr = 1'b0;
        #13;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_outs", 64'({out_data, out_synd, out_ce, out_ue}), 64'(0));
        check("rst_counts", 64'({ce_count, ue_count}), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;

        // Directed words around 0xDEADBEEF
        lat_chk = 1'b1;
        w = 32'hDEADBEEF;
        good = encode(w);
        send(w, good, 1'b1);
        drain();
        check("clean_data", 64'(last_data), 64'(32'hDEADBEEF));
        check("clean_flags", 64'({last_synd, last_ce, last_ue}), 64'(0));
        check("clean_counts", 64'({ce_count, ue_count}), 64'(0));

        send(w ^ 32'h1, good, 1'b1);
        drain();
        check("se_synd", 64'(last_synd), 64'(3));
        check("se_data", 64'(last_data), 64'(32'hDEADBEEF));
        check("se_flags", 64'({last_ce, last_ue}), 64'(2'b10));
        check("se_ce_count", 64'(ce_count), 64'(1));

        send(w ^ 32'h1, good, 1'b0);
        drain();
        check("se_nocorr_data", 64'(last_data), 64'(32'hDEADBEEE));
        check("se_nocorr_ce", 64'(last_ce), 64'(1));

        send(w ^ 32'h3, good, 1'b1);
        drain();
        check("de_synd", 64'(last_synd), 64'(6));
        check("de_flags", 64'({last_ce, last_ue}), 64'(2'b01));
        check("de_data", 64'(last_data), 64'(32'hDEADBEEC));
        check("de_ue_count", 64'(ue_count), 64'(1));

        send(w, good ^ 7'h40, 1'b1);
        drain();
        check("par_synd", 64'(last_synd), 64'(0));
        check("par_flags", 64'({last_ce, last_ue}), 64'(2'b10));
        check("par_data", 64'(last_data), 64'(32'hDEADBEEF));

        // Eight back-to-back words with out_ready low for cycles 3..6
        lat_chk = 1'b0;
        for (int k = 0; k < 8; k++) words[k] = $urandom;
        idx = 0;
        base = n_out;
        for (int t = 0; t < 40 && (idx < 8 || sb.size() != 0); t++) begin
            d = (idx < 8) ? words[idx] : '0;
            tick(idx < 8, d, encode(d), 1'b1, !(t >= 3 && t <= 6), 1'b0, acc);
            if (acc) idx++;
        end
        check("stream_count", 64'(n_out - base), 64'(8));
        drain();

        // Saturation of the 4-bit CE counter, then clear racing a CE handshake
        lat_chk = 1'b1;
        for (int k = 0; k < 17; k++) begin
            d = $urandom;
            c = encode(d);
            corrupt(1, d, c);
            send(d, c, 1'b1);
        end
        drain();
        check("ce_saturated", 64'(ce_count), 64'(15));
        clr_on_out = 1'b1;
        d = $urandom;
        c = encode(d);
        corrupt(1, d, c);
        send(d, c, 1'b1);
        drain();
        clr_on_out = 1'b0;
        check("ce_cleared", 64'(ce_count), 64'(0));

        // Randomized traffic with random backpressure, correction mode and clears
        lat_chk = 1'b0;
        for (int t = 0; t < 400; t++) begin
            d = $urandom;
            c = encode(d);
            corrupt(int'($urandom_range(4)), d, c);
            tick($urandom_range(3) != 0, d, c, $urandom_range(1) != 0,
                 $urandom_range(2) != 0, $urandom_range(40) == 0, acc);
        end
        drain();

        // Asynchronous reset with both stages full and output stalled
        base = 0;
        while (sb.size() < 2 && base < 10) begin
            d = $urandom;
            tick(1'b1, d, encode(d), 1'b1, 1'b0, 1'b0, acc);
            base++;
        end
        check("fill_both", 64'(sb.size()), 64'(2));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_outs", 64'({out_data, out_synd, out_ce, out_ue}), 64'(0));
        check("arst_counts", 64'({ce_count, ue_count}), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(1));
        sb.delete();
        model_ce = 0;
        model_ue = 0;
        stall_prev = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        lat_chk = 1'b1;
        d = 32'h1234_5678;
        send(d ^ 32'h0000_0100, encode(d), 1'b1);
        drain();
        check("post_rst_data", 64'(last_data), 64'(32'h1234_5678));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
